// File: rtl/transfer_center_fifo.sv
// transfer_center_fifo: serial-to-word deserialiser with channel tagging,
// a show-ahead DEPTH-entry FIFO, sender back-pressure and sticky overflow.
module transfer_center_fifo #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CH_BITS   = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         serialIn,
   input  logic                         serialValid,
   input  logic [CH_BITS-1:0]           channelIn,
   input  logic                         abortWord,
   input  logic                         readyForTransferIn,
   output logic                         readyForTransferOut,
   output logic                         wordValid,
   output logic [WIDTH-1:0]             dataBuffer,
   output logic [CH_BITS-1:0]           channelOut,
   output logic [$clog2(WIDTH)-1:0]     bitCount,
   output logic [$clog2(DEPTH):0]       fillLevel,
   output logic                         overflow
);

   localparam int unsigned CNT_W  = $clog2(WIDTH);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RECV, STALL} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     shifter_q;
   logic [CH_BITS-1:0]   chan_q;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic                 overflow_q;

   logic [WIDTH-1:0]     mem_data_q [DEPTH];
   logic [CH_BITS-1:0]   mem_ch_q   [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [FILL_W-1:0]    fill_q;

   logic [WIDTH-1:0]     shift_src;
   logic [WIDTH-1:0]     shifted_d;
   logic [WIDTH-1:0]     push_word;
   logic                 full;
   logic                 pop;
   logic                 complete;
   logic                 push;

   // Next shifter value, word completion and FIFO push/pop decisions
   always_comb begin
      shift_src = '0;
      shifted_d = '0;
      push_word = shifter_q;
      full      = (fill_q == FILL_W'(DEPTH));
      pop       = (fill_q != '0) && readyForTransferIn;
      if (state_q == RECV) begin
         shift_src = shifter_q;
      end
      if (MSB_FIRST) begin
         shifted_d = {shift_src[WIDTH-2:0], serialIn};
      end else begin
         shifted_d = {serialIn, shift_src[WIDTH-1:1]};
      end
      complete = (state_q == RECV) && serialValid && !abortWord &&
                 (bit_cnt_q == CNT_W'(WIDTH - 1));
      push     = (complete && (!full || pop)) || ((state_q == STALL) && !full);
      if (state_q != STALL) begin
         push_word = shifted_d;
      end
   end

   // Receive FSM: bit capture, abort, stall and overflow tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shifter_q  <= '0;
         chan_q     <= '0;
         bit_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (serialValid) begin
                  shifter_q <= shifted_d;
                  chan_q    <= channelIn;
                  bit_cnt_q <= CNT_W'(1);
                  state_q   <= RECV;
               end
            end
            RECV: begin
               if (abortWord) begin
                  shifter_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= IDLE;
               end else if (serialValid) begin
                  shifter_q <= shifted_d;
                  if (complete) begin
                     bit_cnt_q <= '0;
                     state_q   <= push ? IDLE : STALL;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
            end
            STALL: begin
               if (serialValid) begin
                  overflow_q <= 1'b1;
               end
               if (!full) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Show-ahead FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data_q[i] <= '0;
            mem_ch_q[i]   <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push) begin
            mem_data_q[wr_ptr_q] <= push_word;
            mem_ch_q[wr_ptr_q]   <= chan_q;
            wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         fill_q <= fill_q + FILL_W'(push) - FILL_W'(pop);
      end
   end

   assign readyForTransferOut = (state_q != STALL);
   assign wordValid           = (fill_q != '0);
   assign dataBuffer          = mem_data_q[rd_ptr_q];
   assign channelOut          = mem_ch_q[rd_ptr_q];
   assign bitCount            = bit_cnt_q;
   assign fillLevel           = fill_q;
   assign overflow            = overflow_q;

endmodule

// File: tb/tb_transfer_center_fifo.sv
// Directed testbench for transfer_center_fifo (MSB-first and LSB-first instances).
module tb_transfer_center_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       serialIn;
   logic       serialValid;
   logic [1:0] channelIn;
   logic       abortWord;
   logic       readyForTransferIn;

   logic       m_rto, m_wv, m_ovf;
   logic [7:0] m_data;
   logic [1:0] m_ch;
   logic [2:0] m_bc;
   logic [2:0] m_fill;

   logic       l_rto, l_wv, l_ovf;
   logic [7:0] l_data;
   logic [1:0] l_ch;
   logic [2:0] l_bc;
   logic [2:0] l_fill;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   transfer_center_fifo #(.WIDTH(8), .DEPTH(4), .CH_BITS(2), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .serialIn(serialIn), .serialValid(serialValid),
      .channelIn(channelIn), .abortWord(abortWord),
      .readyForTransferIn(readyForTransferIn), .readyForTransferOut(m_rto),
      .wordValid(m_wv), .dataBuffer(m_data), .channelOut(m_ch),
      .bitCount(m_bc), .fillLevel(m_fill), .overflow(m_ovf)
   );

   transfer_center_fifo #(.WIDTH(8), .DEPTH(4), .CH_BITS(2), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .serialIn(serialIn), .serialValid(serialValid),
      .channelIn(channelIn), .abortWord(abortWord),
      .readyForTransferIn(readyForTransferIn), .readyForTransferOut(l_rto),
      .wordValid(l_wv), .dataBuffer(l_data), .channelOut(l_ch),
      .bitCount(l_bc), .fillLevel(l_fill), .overflow(l_ovf)
   );

   // Stimulus: one strobed bit, then sample 1 time unit after the edge
   task automatic send_bit(input logic b);
      serialIn    = b;
      serialValid = 1'b1;
      @(posedge clk); #1;
      serialValid = 1'b0;
   endtask

   // Stimulus: a full word, bit 7 first
   task automatic send_word(input logic [7:0] w, input logic [1:0] ch);
      channelIn = ch;
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; serialIn = 1'b0; serialValid = 1'b0; channelIn = 2'b00;
      abortWord = 1'b0; readyForTransferIn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (m_wv !== 1'b0) begin errors++; $display("FAIL reset_wv got=%b exp=0", m_wv); end
      tests++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", m_data); end
      tests++; if (m_fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", m_fill); end
      tests++; if (m_rto !== 1'b1) begin errors++; $display("FAIL reset_rto got=%b exp=1", m_rto); end
      tests++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", m_ovf); end
      rst = 1'b0;
      idle_cycle();
   endtask

   task automatic test_basic_word();
      send_word(8'b1110_0000, 2'b10);
      tests++; if (m_wv !== 1'b1) begin errors++; $display("FAIL t1_wv got=%b exp=1", m_wv); end
      tests++; if (m_data !== 8'b1110_0000) begin errors++; $display("FAIL t1_data got=%b exp=11100000", m_data); end
      tests++; if (m_ch !== 2'b10) begin errors++; $display("FAIL t1_ch got=%b exp=10", m_ch); end
      tests++; if (m_fill !== 3'd1) begin errors++; $display("FAIL t1_fill got=%0d exp=1", m_fill); end
      tests++; if (m_bc !== 3'd0) begin errors++; $display("FAIL t1_bc got=%0d exp=0", m_bc); end
      tests++; if (l_data !== 8'b0000_0111) begin errors++; $display("FAIL t2_lsb_data got=%b exp=00000111", l_data); end
      tests++; if (l_ch !== 2'b10) begin errors++; $display("FAIL t2_lsb_ch got=%b exp=10", l_ch); end
      readyForTransferIn = 1'b1;
      idle_cycle();
      readyForTransferIn = 1'b0;
      tests++; if (m_fill !== 3'd0) begin errors++; $display("FAIL t1_pop_fill got=%0d exp=0", m_fill); end
      tests++; if (m_wv !== 1'b0) begin errors++; $display("FAIL t1_pop_wv got=%b exp=0", m_wv); end
      tests++; if (l_fill !== 3'd0) begin errors++; $display("FAIL t2_pop_fill got=%0d exp=0", l_fill); end
   endtask

   task automatic test_stall_overflow();
      logic [7:0] exp_w [4];
      exp_w[0] = 8'h22; exp_w[1] = 8'h33; exp_w[2] = 8'h44; exp_w[3] = 8'h55;
      readyForTransferIn = 1'b0;
      send_word(8'h11, 2'd0);
      send_word(8'h22, 2'd1);
      send_word(8'h33, 2'd2);
      send_word(8'h44, 2'd3);
      tests++; if (m_fill !== 3'd4) begin errors++; $display("FAIL t3_full got=%0d exp=4", m_fill); end
      tests++; if (m_data !== 8'h11) begin errors++; $display("FAIL t3_head got=%h exp=11", m_data); end
      send_word(8'h55, 2'd1);
      tests++; if (m_rto !== 1'b0) begin errors++; $display("FAIL t3_stall_rto got=%b exp=0", m_rto); end
      tests++; if (m_fill !== 3'd4) begin errors++; $display("FAIL t3_stall_fill got=%0d exp=4", m_fill); end
      tests++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL t3_ovf_pre got=%b exp=0", m_ovf); end
      send_bit(1'b1);
      tests++; if (m_ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf got=%b exp=1", m_ovf); end
      readyForTransferIn = 1'b1;
      idle_cycle();
      readyForTransferIn = 1'b0;
      tests++; if (m_fill !== 3'd3) begin errors++; $display("FAIL t3_popped_fill got=%0d exp=3", m_fill); end
      tests++; if (m_rto !== 1'b0) begin errors++; $display("FAIL t3_still_stall got=%b exp=0", m_rto); end
      idle_cycle();
      tests++; if (m_fill !== 3'd4) begin errors++; $display("FAIL t3_commit_fill got=%0d exp=4", m_fill); end
      tests++; if (m_rto !== 1'b1) begin errors++; $display("FAIL t3_commit_rto got=%b exp=1", m_rto); end
      readyForTransferIn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (m_data !== exp_w[i]) begin errors++; $display("FAIL t3_drain%0d got=%h exp=%h", i, m_data, exp_w[i]); end
         idle_cycle();
      end
      readyForTransferIn = 1'b0;
      tests++; if (m_wv !== 1'b0) begin errors++; $display("FAIL t3_empty got=%b exp=0", m_wv); end
      tests++; if (m_ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf_sticky got=%b exp=1", m_ovf); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] exp_w [4];
      exp_w[0] = 8'h02; exp_w[1] = 8'h03; exp_w[2] = 8'h04; exp_w[3] = 8'hA5;
      readyForTransferIn = 1'b0;
      send_word(8'h01, 2'd0);
      send_word(8'h02, 2'd0);
      send_word(8'h03, 2'd0);
      send_word(8'h04, 2'd0);
      channelIn = 2'd3;
      for (int i = 7; i >= 1; i--) send_bit(8'hA5 >> i);
      readyForTransferIn = 1'b1;
      send_bit(1'b1);
      readyForTransferIn = 1'b0;
      tests++; if (m_rto !== 1'b1) begin errors++; $display("FAIL t4_no_stall got=%b exp=1", m_rto); end
      tests++; if (m_fill !== 3'd4) begin errors++; $display("FAIL t4_fill got=%0d exp=4", m_fill); end
      readyForTransferIn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (m_data !== exp_w[i]) begin errors++; $display("FAIL t4_drain%0d got=%h exp=%h", i, m_data, exp_w[i]); end
         if (i == 3) begin
            tests++;
            if (m_ch !== 2'd3) begin errors++; $display("FAIL t4_tag got=%0d exp=3", m_ch); end
         end
         idle_cycle();
      end
      readyForTransferIn = 1'b0;
      tests++; if (m_fill !== 3'd0) begin errors++; $display("FAIL t4_empty got=%0d exp=0", m_fill); end
   endtask

   task automatic test_abort();
      channelIn = 2'd1;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      tests++; if (m_bc !== 3'd3) begin errors++; $display("FAIL t5_bc3 got=%0d exp=3", m_bc); end
      abortWord = 1'b1;
      send_bit(1'b1);
      abortWord = 1'b0;
      tests++; if (m_bc !== 3'd0) begin errors++; $display("FAIL t5_abort_bc got=%0d exp=0", m_bc); end
      tests++; if (m_fill !== 3'd0) begin errors++; $display("FAIL t5_abort_fill got=%0d exp=0", m_fill); end
      send_word(8'h3C, 2'd2);
      tests++; if (m_data !== 8'h3C) begin errors++; $display("FAIL t5_data got=%h exp=3c", m_data); end
      tests++; if (m_ch !== 2'd2) begin errors++; $display("FAIL t5_ch got=%0d exp=2", m_ch); end
      tests++; if (m_fill !== 3'd1) begin errors++; $display("FAIL t5_fill got=%0d exp=1", m_fill); end
      readyForTransferIn = 1'b1;
      idle_cycle();
      readyForTransferIn = 1'b0;
   endtask

   task automatic test_async_reset();
      send_word(8'h5A, 2'd1);
      send_word(8'hC3, 2'd2);
      channelIn = 2'd0;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      tests++; if (m_fill !== 3'd2) begin errors++; $display("FAIL t6_pre_fill got=%0d exp=2", m_fill); end
      tests++; if (m_bc !== 3'd5) begin errors++; $display("FAIL t6_pre_bc got=%0d exp=5", m_bc); end
      #2 rst = 1'b1;
      #1;
      tests++; if (m_wv !== 1'b0) begin errors++; $display("FAIL t6_wv got=%b exp=0", m_wv); end
      tests++; if (m_fill !== 3'd0) begin errors++; $display("FAIL t6_fill got=%0d exp=0", m_fill); end
      tests++; if (m_bc !== 3'd0) begin errors++; $display("FAIL t6_bc got=%0d exp=0", m_bc); end
      tests++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL t6_ovf got=%b exp=0", m_ovf); end
      tests++; if (m_rto !== 1'b1) begin errors++; $display("FAIL t6_rto got=%b exp=1", m_rto); end
      tests++; if (m_data !== 8'h00) begin errors++; $display("FAIL t6_data got=%h exp=00", m_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_stall_overflow();
      test_push_pop_full();
      test_abort();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
